// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and sizing helpers for the v68k flag-maintaining ALU.
//   alu_op_e    operation codes (4 bits)
//   alu_state_e ALU sequencer states
//   ccr_t       condition code register payload {x, n, z, v, c}
//   size_msb()  sized MSB index for byte/word/long (11 treated as long)
//   size_mask() sized operand mask
//   is_shift()  true for the multi-cycle shift/rotate ops
package alu_pkg;

   localparam int unsigned ALU_W  = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned MSB_W  = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_ADDX = 4'd1,
      OP_SUB  = 4'd2,
      OP_SUBX = 4'd3,
      OP_CMP  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_EOR  = 4'd7,
      OP_NEG  = 4'd8,
      OP_ASL  = 4'd9,
      OP_ASR  = 4'd10,
      OP_LSL  = 4'd11,
      OP_LSR  = 4'd12,
      OP_ROL  = 4'd13,
      OP_ROR  = 4'd14,
      OP_NOP  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic x;
      logic n;
      logic z;
      logic v;
      logic c;
   } ccr_t;

   function automatic logic [MSB_W-1:0] size_msb(input logic [SIZE_W-1:0] size);
      case (size)
         2'b00:   return 5'd7;
         2'b01:   return 5'd15;
         default: return 5'd31;
      endcase
   endfunction

   function automatic logic [ALU_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
      case (size)
         2'b00:   return 32'h0000_00FF;
         2'b01:   return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op >= 4'(OP_ASL)) && (op <= 4'(OP_ROR));
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: one-bit sized shift/rotate step.
//   value        current operand (bits above the sized field pass through)
//   op           ASL/ASR/LSL/LSR/ROL/ROR; any other op passes value through
//   size         00 byte, 01 word, 1x long
//   next_value   value after one step
//   bit_out      bit shifted/rotated out of the sized field
//   msb_changed  sized MSB differs between value and next_value
module alu_shifter
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0]  value,
   input  alu_op_e           op,
   input  logic [SIZE_W-1:0] size,
   output logic [ALU_W-1:0]  next_value,
   output logic              bit_out,
   output logic              msb_changed
);

   logic [MSB_W-1:0] msb;
   logic [ALU_W-1:0] mask;
   logic [ALU_W-1:0] field;
   logic [ALU_W-1:0] shifted;
   logic             top;

   always_comb begin
      msb         = size_msb(size);
      mask        = size_mask(size);
      field       = value & mask;
      top         = value[msb];
      shifted     = field;
      bit_out     = 1'b0;
      case (op)
         OP_ASL, OP_LSL: begin
            shifted = field << 1;
            bit_out = top;
         end
         OP_ROL: begin
            shifted = (field << 1) | {{(ALU_W-1){1'b0}}, top};
            bit_out = top;
         end
         // Arithmetic right keeps the sign bit of the sized field
         OP_ASR: begin
            shifted = (field >> 1) | ({{(ALU_W-1){1'b0}}, top} << msb);
            bit_out = value[0];
         end
         OP_LSR: begin
            shifted = field >> 1;
            bit_out = value[0];
         end
         OP_ROR: begin
            shifted = (field >> 1) | ({{(ALU_W-1){1'b0}}, value[0]} << msb);
            bit_out = value[0];
         end
         default: ;
      endcase
      msb_changed = shifted[msb] ^ top;
      next_value  = (value & ~mask) | (shifted & mask);
   end

endmodule

// File: rtl/alu_core.sv
// alu_core: sized integer ALU with persistent CCR and start/ready/done handshake.
//   clk, rst       clock, asynchronous active-high reset
//   start          request, accepted only while ready
//   op, size       operation (alu_op_e) and operand size
//   a, b, cnt      destination, source operand and shift count
//   ready          idle and able to accept start
//   done           one-cycle pulse, o and flags valid
//   o              result (bits above the sized field copy a)
//   x, n, z, v, c  condition code flags, held until the next completed op
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CNT_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [OP_W-1:0]     op,
   input  logic [SIZE_W-1:0]   size,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [CNT_BITS-1:0] cnt,
   output logic                ready,
   output logic                done,
   output logic [WIDTH-1:0]    o,
   output logic                x,
   output logic                n,
   output logic                z,
   output logic                v,
   output logic                c
);

   alu_state_e          state, state_nx;
   alu_op_e             op_r;
   logic [SIZE_W-1:0]   size_r;
   logic [WIDTH-1:0]    a_r, b_r;
   logic [CNT_BITS-1:0] cnt_r;
   logic                shifted_r;
   logic                c_sh, v_sh;
   ccr_t                ccr, ccr_nx;
   logic [WIDTH-1:0]    res;

   logic [WIDTH-1:0]    sh_next;
   logic                sh_out, sh_chg;

   logic [MSB_W-1:0]    msb;
   logic [WIDTH-1:0]    mask;
   logic [WIDTH-1:0]    opd, ops, sized;
   logic [WIDTH:0]      wide;
   logic                cin, carry, d_msb, s_msb, r_zero;

   assign x = ccr.x;
   assign n = ccr.n;
   assign z = ccr.z;
   assign v = ccr.v;
   assign c = ccr.c;

   alu_shifter u_shifter (
      .value       (a_r),
      .op          (op_r),
      .size        (size_r),
      .next_value  (sh_next),
      .bit_out     (sh_out),
      .msb_changed (sh_chg)
   );

   // Sequencer state register; ready is registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         ready <= 1'b1;
      end else begin
         state <= state_nx;
         ready <= (state_nx == ST_IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = (is_shift(op) && (cnt != '0)) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == CNT_BITS'(1)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Final result and CCR from the latched operands (or the shifted value)
   always_comb begin
      msb    = size_msb(size_r);
      mask   = size_mask(size_r);
      opd    = a_r & mask;
      ops    = b_r & mask;
      if (op_r == OP_NEG) begin
         opd = '0;
         ops = a_r & mask;
      end
      cin    = ((op_r == OP_ADDX) || (op_r == OP_SUBX)) ? ccr.x : 1'b0;
      if ((op_r == OP_ADD) || (op_r == OP_ADDX)) begin
         wide = {1'b0, opd} + {1'b0, ops} + {{WIDTH{1'b0}}, cin};
      end else begin
         wide = {1'b0, opd} - {1'b0, ops} - {{WIDTH{1'b0}}, cin};
      end
      // Carry/borrow emerges just above the sized MSB
      carry  = wide[6'(msb) + 6'd1];
      d_msb  = opd[msb];
      s_msb  = ops[msb];
      sized  = wide[WIDTH-1:0] & mask;
      ccr_nx = ccr;
      case (op_r)
         OP_ADD, OP_ADDX: begin
            ccr_nx.v = (d_msb == s_msb) && (sized[msb] != d_msb);
            ccr_nx.c = carry;
            ccr_nx.x = carry;
         end
         OP_SUB, OP_SUBX, OP_NEG, OP_CMP: begin
            ccr_nx.v = (d_msb != s_msb) && (sized[msb] != d_msb);
            ccr_nx.c = carry;
            if (op_r != OP_CMP) begin
               ccr_nx.x = carry;
            end
         end
         OP_AND, OP_OR, OP_EOR: begin
            case (op_r)
               OP_AND:  sized = a_r & b_r & mask;
               OP_OR:   sized = (a_r | b_r) & mask;
               default: sized = (a_r ^ b_r) & mask;
            endcase
            ccr_nx.v = 1'b0;
            ccr_nx.c = 1'b0;
         end
         OP_ASL, OP_ASR, OP_LSL, OP_LSR, OP_ROL, OP_ROR: begin
            sized    = a_r & mask;
            ccr_nx.v = v_sh;
            ccr_nx.c = c_sh;
            if (shifted_r && (op_r != OP_ROL) && (op_r != OP_ROR)) begin
               ccr_nx.x = c_sh;
            end
         end
         default: sized = a_r & mask;
      endcase
      r_zero   = (sized == '0);
      ccr_nx.n = sized[msb];
      // Extended ops only ever clear Z so multi-precision chains accumulate it
      if ((op_r == OP_ADDX) || (op_r == OP_SUBX)) begin
         ccr_nx.z = r_zero ? ccr.z : 1'b0;
      end else begin
         ccr_nx.z = r_zero;
      end
      if (op_r == OP_NOP) begin
         ccr_nx = ccr;
      end
      res = (op_r == OP_CMP) ? a_r : ((a_r & ~mask) | sized);
   end

   // Operand latch, shift stepping and result/flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= OP_ADD;
         size_r    <= '0;
         a_r       <= '0;
         b_r       <= '0;
         cnt_r     <= '0;
         shifted_r <= 1'b0;
         c_sh      <= 1'b0;
         v_sh      <= 1'b0;
         o         <= '0;
         ccr       <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_r      <= alu_op_e'(op);
                  size_r    <= size;
                  a_r       <= a;
                  b_r       <= b;
                  cnt_r     <= cnt;
                  shifted_r <= (cnt != '0);
                  c_sh      <= 1'b0;
                  v_sh      <= 1'b0;
               end
            end
            ST_SHIFT: begin
               a_r   <= sh_next;
               c_sh  <= sh_out;
               v_sh  <= v_sh | (sh_chg && (op_r == OP_ASL));
               cnt_r <= cnt_r - CNT_BITS'(1);
            end
            ST_DONE: begin
               o    <= res;
               ccr  <= ccr_nx;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table, randomized ops against an integer
// reference model, and hand sequences for busy-start and mid-shift reset.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [1:0]  size;
   logic [31:0] a, b;
   logic [5:0]  cnt;
   logic        ready, done;
   logic [31:0] o;
   logic        x, n, z, v, c;

   int tests = 0;
   int fails = 0;

   alu_core #(.WIDTH(32), .CNT_BITS(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .size(size),
      .a(a), .b(b), .cnt(cnt), .ready(ready), .done(done), .o(o),
      .x(x), .n(n), .z(z), .v(v), .c(c)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] b;
      int          cnt;
      logic [31:0] eo;
      logic [4:0]  ef;   // {x,n,z,v,c}
      int          elat;
   } vec_t;

   typedef struct {
      logic [31:0] o;
      logic [4:0]  f;
   } mres_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {x, n, z, v, c};
   endfunction

   // Reference model: sized integer arithmetic on 64-bit values
   function automatic mres_t model(input logic [3:0] mop, input logic [1:0] sz,
                                   input logic [31:0] ma, input logic [31:0] mb,
                                   input int mcnt, input logic [4:0] f);
      mres_t  r;
      int     bits;
      longint mask, half, ua, ub, sa, sb, full, sr, res, nr;
      logic   fx, fn, fz, fv, fc, cc, vv, bin;
      bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
      mask = (64'sd1 <<< bits) - 1;
      half = 64'sd1 <<< (bits - 1);
      ua   = longint'(ma) & mask;
      ub   = longint'(mb) & mask;
      {fx, fn, fz, fv, fc} = f;
      if (mop == 4'd8) begin ub = ua; ua = 0; end
      sa   = (ua >= half) ? ua - (64'sd1 <<< bits) : ua;
      sb   = (ub >= half) ? ub - (64'sd1 <<< bits) : ub;
      bin  = ((mop == 4'd1) || (mop == 4'd3)) ? fx : 1'b0;
      res  = ua;
      case (mop)
         4'd0, 4'd1: begin
            full = ua + ub + longint'(bin);
            sr   = sa + sb + longint'(bin);
            res  = full & mask;
            fc   = (full > mask);
            fv   = (sr >= half) || (sr < -half);
            fx   = fc;
         end
         4'd2, 4'd3, 4'd4, 4'd8: begin
            full = ua - ub - longint'(bin);
            sr   = sa - sb - longint'(bin);
            res  = full & mask;
            fc   = (full < 0);
            fv   = (sr >= half) || (sr < -half);
            if (mop != 4'd4) fx = fc;
         end
         4'd5: begin res = ua & ub; fv = 0; fc = 0; end
         4'd6: begin res = ua | ub; fv = 0; fc = 0; end
         4'd7: begin res = ua ^ ub; fv = 0; fc = 0; end
         default: begin
            cc = 0; vv = 0;
            for (int i = 0; i < mcnt; i++) begin
               case (mop)
                  4'd9, 4'd11: begin
                     cc = (res >= half);
                     nr = (res <<< 1) & mask;
                     if ((mop == 4'd9) && ((nr >= half) != (res >= half))) vv = 1;
                     res = nr;
                  end
                  4'd10: begin cc = res[0]; res = (res >>> 1) | (res & half); end
                  4'd12: begin cc = res[0]; res = res >>> 1; end
                  4'd13: begin cc = (res >= half); res = ((res <<< 1) & mask) | longint'(cc); end
                  default: begin cc = res[0]; res = (res >>> 1) | (cc ? half : 0); end
               endcase
            end
            fc = cc;
            fv = vv;
            if ((mop >= 4'd9) && (mop <= 4'd12) && (mcnt > 0)) fx = cc;
         end
      endcase
      fn = (res >= half);
      if ((mop == 4'd1) || (mop == 4'd3)) fz = (res == 0) ? fz : 1'b0;
      else fz = (res == 0);
      r.o = (mop == 4'd4) ? ma : ((ma & ~32'(mask)) | 32'(res));
      r.f = {fx, fn, fz, fv, fc};
      return r;
   endfunction

   // Issue one op starting just after a rising edge; lat = edges after accept until done
   task automatic do_op(input logic [3:0] t_op, input logic [1:0] t_sz, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int t_cnt, output int lat);
      int guard;
      guard = 0;
      while (!ready && guard < 200) begin @(posedge clk); #1; guard++; end
      if (!ready) begin
         tests++; fails++;
         $display("FAIL ready_wait: got ready=%b expected 1", ready);
      end
      op = t_op; size = t_sz; a = t_a; b = t_b; cnt = 6'(t_cnt);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!done && lat < 200);
   endtask

   vec_t        vt[10];
   logic [4:0]  mf;
   mres_t       er;
   int          lat, dcount;
   logic [3:0]  rop;
   logic [1:0]  rsz;
   logic [31:0] ra, rb;
   int          rcnt, elat;

   initial begin
      vt[0] = '{4'(OP_ADD),  2'b01, 32'h0000_7FFF, 32'h0000_0001, 0, 32'h0000_8000, 5'b01010, 1};
      vt[1] = '{4'(OP_ADD),  2'b01, 32'h0000_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 5'b10101, 1};
      vt[2] = '{4'(OP_ADDX), 2'b01, 32'h0000_0000, 32'h0000_FFFF, 0, 32'h0000_0000, 5'b10101, 1};
      vt[3] = '{4'(OP_ADDX), 2'b01, 32'h0000_0001, 32'h0000_0001, 0, 32'h0000_0003, 5'b00000, 1};
      vt[4] = '{4'(OP_SUB),  2'b00, 32'h1234_5600, 32'h0000_0001, 0, 32'h1234_56FF, 5'b11001, 1};
      vt[5] = '{4'(OP_CMP),  2'b10, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0005, 5'b10100, 1};
      vt[6] = '{4'(OP_ASL),  2'b10, 32'h4000_0000, 32'h0000_0000, 2, 32'h0000_0000, 5'b10111, 3};
      vt[7] = '{4'(OP_LSL),  2'b10, 32'h8000_0001, 32'h0000_0000, 2, 32'h0000_0004, 5'b00000, 3};
      vt[8] = '{4'(OP_ROR),  2'b01, 32'h0000_0001, 32'h0000_0000, 1, 32'h0000_8000, 5'b01001, 2};
      vt[9] = '{4'(OP_LSR),  2'b10, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 5'b00100, 1};

      rst = 1'b1; start = 1'b0; op = '0; size = '0; a = '0; b = '0; cnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("reset_o", o, 32'h0);
      check("reset_flags", 32'(flags()), 32'h0);
      check("reset_ready", 32'(ready), 32'h1);
      check("reset_done", 32'(done), 32'h0);
      @(posedge clk); #1;

      // Directed vectors, each started in the done cycle of the previous
      for (int i = 0; i < 10; i++) begin
         do_op(vt[i].op, vt[i].sz, vt[i].a, vt[i].b, vt[i].cnt, lat);
         check($sformatf("vec%0d_o", i), o, vt[i].eo);
         check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vt[i].ef));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].elat));
      end
      mf = vt[9].ef;

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         rop = 4'($urandom_range(0, 14));
         rsz = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         rcnt = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 12);
         er = model(rop, rsz, ra, rb, rcnt, mf);
         elat = (is_shift(rop) && rcnt != 0) ? rcnt + 1 : 1;
         do_op(rop, rsz, ra, rb, rcnt, lat);
         check($sformatf("rnd%0d_op%0d_o", i, rop), o, er.o);
         check($sformatf("rnd%0d_op%0d_flags", i, rop), 32'(flags()), 32'(er.f));
         check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
         mf = er.f;
      end

      // start pulsed while shifting must be ignored
      er = model(4'(OP_LSL), 2'b10, 32'h1, 32'h0, 5, mf);
      op = 4'(OP_LSL); size = 2'b10; a = 32'h1; b = 32'h0; cnt = 6'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 0;
      @(posedge clk); #1; lat++;
      @(posedge clk); #1; lat++;
      check("busy_ready", 32'(ready), 32'h0);
      op = 4'(OP_ADD); a = 32'hFFFF_FFFF; b = 32'h1; cnt = 6'd0; start = 1'b1;
      @(posedge clk); #1; lat++;
      start = 1'b0;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      check("busy_o", o, 32'h0000_0020);
      check("busy_flags", 32'(flags()), 32'(er.f));
      check("busy_latency", 32'(lat), 32'd6);
      mf = er.f;
      dcount = 0;
      repeat (4) begin @(posedge clk); #1; if (done) dcount++; end
      check("busy_no_extra_done", 32'(dcount), 32'h0);

      // Reset during a long shift aborts with no done
      op = 4'(OP_LSR); size = 2'b10; a = 32'hFFFF_FFFF; b = 32'h0; cnt = 6'd40; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("pre_reset_busy", 32'(ready), 32'h0);
      rst = 1'b1;
      #1;
      check("midrst_o", o, 32'h0);
      check("midrst_flags", 32'(flags()), 32'h0);
      check("midrst_ready", 32'(ready), 32'h1);
      check("midrst_done", 32'(done), 32'h0);
      @(negedge clk) rst = 1'b0;
      dcount = 0;
      repeat (45) begin @(posedge clk); #1; if (done) dcount++; end
      check("midrst_no_done", 32'(dcount), 32'h0);
      check("midrst_ready_after", 32'(ready), 32'h1);

      // Post-reset operation starts from cleared flags (ADDX sees X=0)
      er = model(4'(OP_ADDX), 2'b00, 32'h0000_00FF, 32'h0000_0001, 0, 5'b00000);
      do_op(4'(OP_ADDX), 2'b00, 32'h0000_00FF, 32'h0000_0001, 0, lat);
      check("post_rst_o", o, er.o);
      check("post_rst_flags", 32'(flags()), 32'(er.f));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
